jam_cost_loader: RTL and testbench

Upstream stage of the JAM job-assignment solver. Accepts the 8×8 worker/job cost matrix as a row-major valid/ready word stream and stores it. Once loaded, it serves the solver's (W, J) lookups with a zero-latency combinational Cost read. It holds the solver in reset until the table is complete and computes a row-minimum lower bound on MinCost during the load.

---
 rtl/jam_pkg.sv | 18 +
 rtl/jam_cost_mem.sv | 29 ++
 rtl/jam_cost_loader.sv | 102 ++++++++++
 tb/tb_jam_cost_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Constants and types shared by the JAM cost loader and the solver.
package jam_pkg;

    localparam int N  = 8;
    localparam int CW = 7;
    localparam int SW = 10;
    localparam int IW = $clog2(N * N);

    typedef enum logic {
        LOAD,
        DONE
    } state_t;

    function automatic logic [CW-1:0] min_cost(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/jam_cost_mem.sv
// N*N x CW cost register file: one write port, one combinational read port.
module jam_cost_mem
    import jam_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic [IW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem [N*N];

    // Every word resets to zero so reads before the first load are well defined.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N * N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/jam_cost_loader.sv
// Loads the 8x8 JAM cost matrix from a word stream, serves combinational
// lookups and tracks a row-minimum lower bound while holding the solver in reset.
module jam_cost_loader
    import jam_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_data,
    input  logic          in_last,
    input  logic          reload,
    input  logic [2:0]    W,
    input  logic [2:0]    J,
    output logic [CW-1:0] Cost,
    output logic          table_ready,
    output logic          solver_rst,
    output logic [SW-1:0] lower_bound,
    output logic          frame_err
);

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] k;
    logic [CW-1:0] rowmin;
    logic          accept;
    logic          last_word;
    logic          row_end;
    logic [CW-1:0] cur_min;

    assign accept    = in_valid & in_ready;
    assign last_word = (k == IW'(N * N - 1));
    assign row_end   = (k[2:0] == 3'(N - 1));
    assign cur_min   = (k[2:0] == 3'd0) ? in_data : min_cost(rowmin, in_data);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (accept && last_word) state_next = DONE;
            DONE:    if (reload) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        in_ready    = (state == LOAD);
        table_ready = (state == DONE);
    end

    // An early in_last restarts the frame from word 0; a missing in_last on
    // word 63 is flagged but the table is still taken as complete.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k           <= '0;
            rowmin      <= '0;
            lower_bound <= '0;
            frame_err   <= 1'b0;
            solver_rst  <= 1'b1;
        end else begin
            solver_rst <= (state_next == LOAD);
            if (state == DONE && reload) begin
                k           <= '0;
                lower_bound <= '0;
                frame_err   <= 1'b0;
            end else if (accept) begin
                if (last_word) begin
                    k           <= '0;
                    lower_bound <= lower_bound + SW'(cur_min);
                    if (!in_last) frame_err <= 1'b1;
                end else if (in_last) begin
                    k           <= '0;
                    rowmin      <= '0;
                    lower_bound <= '0;
                    frame_err   <= 1'b1;
                end else begin
                    k      <= k + IW'(1);
                    rowmin <= cur_min;
                    if (row_end) lower_bound <= lower_bound + SW'(cur_min);
                end
            end
        end
    end

    jam_cost_mem u_mem (
        .CLK   (CLK),
        .RST   (RST),
        .we    (accept),
        .waddr (k),
        .wdata (in_data),
        .raddr ({W, J}),
        .rdata (Cost)
    );

endmodule

// File: tb/tb_jam_cost_loader.sv
// Directed bench for jam_cost_loader with a matrix-level reference model
// checked every cycle plus hand-computed expectations.
module tb_jam_cost_loader;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_data;
    logic       in_last;
    logic       reload;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       table_ready;
    logic       solver_rst;
    logic [9:0] lower_bound;
    logic       frame_err;

    jam_cost_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .reload      (reload),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .table_ready (table_ready),
        .solver_rst  (solver_rst),
        .lower_bound (lower_bound),
        .frame_err   (frame_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // Reference model: the table, the frame being received and the load status.
    logic [6:0] m_mem   [64];
    logic [6:0] m_frame [64];
    bit         m_loading;
    int         m_count;
    int         m_lb;
    bit         m_ferr;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sum of row minima over the rows of the current frame received so far.
    function automatic int partial_lb(input int cnt);
        int s = 0;
        for (int r = 0; r < 8; r++) begin
            if ((r + 1) * 8 <= cnt) begin
                int mn = m_frame[r*8];
                for (int c = 1; c < 8; c++)
                    if (m_frame[r*8+c] < mn) mn = m_frame[r*8+c];
                s += mn;
            end
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
        m_loading = 1'b1;
        m_count   = 0;
        m_lb      = 0;
        m_ferr    = 1'b0;
    endtask

    // One clock: drive inputs, let the edge happen, advance the model.
    task automatic apply_stimulus(input bit v, input int d, input bit last, input bit rl);
        in_valid = v;
        in_data  = 7'(d);
        in_last  = last;
        reload   = rl;
        W = 3'($urandom_range(0, 7));
        J = 3'($urandom_range(0, 7));
        @(posedge CLK);
        #1;
        if (m_loading && v) begin
            m_mem[m_count]   = 7'(d);
            m_frame[m_count] = 7'(d);
            if (m_count == 63) begin
                m_lb      = partial_lb(64);
                m_loading = 1'b0;
                m_count   = 0;
                if (!last) m_ferr = 1'b1;
            end else if (last) begin
                m_ferr  = 1'b1;
                m_count = 0;
                m_lb    = 0;
            end else begin
                m_count++;
                m_lb = partial_lb(m_count);
            end
        end else if (!m_loading && rl) begin
            m_loading = 1'b1;
            m_count   = 0;
            m_lb      = 0;
            m_ferr    = 1'b0;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        reload   = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            check_output("in_ready",    in_ready,    m_loading);
            check_output("table_ready", table_ready, !m_loading);
            check_output("solver_rst",  solver_rst,  m_loading);
            check_output("lower_bound", lower_bound, m_lb);
            check_output("frame_err",   frame_err,   m_ferr);
            check_output("cost",        Cost,        m_mem[{W, J}]);
        end
    end

    task automatic read_cost(input int w, input int j, input int exp, input string name);
        W = 3'(w);
        J = 3'(j);
        #1;
        check_output(name, Cost, exp);
    endtask

    task automatic load_frame(input int kind);
        for (int i = 0; i < 64; i++) begin
            int v;
            case (kind)
                0:       v = i % 100;
                1:       v = 5;
                2:       v = 127;
                default: v = ((i / 8) == (i % 8)) ? 1 : 50;
            endcase
            apply_stimulus(1'b1, v, i == 63, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rise;
        int i;
        int guard;
        bit v;

        RST = 1'b1; in_valid = 0; in_data = 0; in_last = 0; reload = 0; W = 0; J = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_output("rst_in_ready",    in_ready,    1);
        check_output("rst_table_ready", table_ready, 0);
        check_output("rst_solver_rst",  solver_rst,  1);
        check_output("rst_lower_bound", lower_bound, 0);
        check_output("rst_frame_err",   frame_err,   0);
        check_output("rst_cost",        Cost,        0);
        RST = 1'b0;
        check_en = 1'b1;

        $display("[TB] continuous load k mod 100");
        rise = -1;
        for (int n = 0; n < 64; n++) begin
            apply_stimulus(1'b1, n % 100, n == 63, 1'b0);
            if (table_ready && rise < 0) rise = n + 1;
        end
        check_output("ready_latency", rise, 64);
        read_cost(3, 5, 29, "cost_3_5");
        check_output("lb_ramp", lower_bound, 224);
        check_output("ferr_clean", frame_err, 0);

        $display("[TB] gapped load of the same matrix");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        i = 0;
        guard = 0;
        while (i < 64 && guard < 1000) begin
            v = 1'($urandom_range(0, 1));
            apply_stimulus(v, i, i == 63, 1'b0);
            if (v) i++;
            guard++;
        end
        check_output("gapped_words_taken", i, 64);
        check_output("lb_gapped", lower_bound, 224);
        for (int a = 0; a < 64; a++) read_cost(a / 8, a % 8, a, "cost_gapped");

        $display("[TB] aborted frame then all fives");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        for (int n = 0; n <= 10; n++) apply_stimulus(1'b1, 5, n == 10, 1'b0);
        check_output("ferr_abort", frame_err, 1);
        check_output("lb_abort", lower_bound, 0);
        load_frame(1);
        check_output("lb_fives", lower_bound, 40);
        check_output("ferr_sticky", frame_err, 1);
        for (int a = 0; a < 64; a++) read_cost(a / 8, a % 8, 5, "cost_fives");

        $display("[TB] all-127 matrix and reload");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        load_frame(2);
        check_output("lb_max", lower_bound, 1016);
        check_output("ferr_max", frame_err, 0);
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        check_output("reload_table_ready", table_ready, 0);
        check_output("reload_solver_rst",  solver_rst,  1);
        check_output("reload_frame_err",   frame_err,   0);
        check_output("reload_lb",          lower_bound, 0);
        read_cost(2, 6, 127, "cost_kept");

        $display("[TB] diagonal matrix, solver release");
        for (int n = 0; n < 64; n++) begin
            apply_stimulus(1'b1, ((n / 8) == (n % 8)) ? 1 : 50, n == 63, 1'b0);
            if (n == 62) check_output("solver_held", solver_rst, 1);
        end
        check_output("solver_released", solver_rst, 0);
        check_output("lb_diag", lower_bound, 8);
        read_cost(4, 4, 1, "cost_diag");
        read_cost(4, 5, 50, "cost_offdiag");

        $display("[TB] reset mid-load");
        apply_stimulus(1'b0, 0, 1'b0, 1'b1);
        for (int n = 0; n < 30; n++) apply_stimulus(1'b1, 77, 1'b0, 1'b0);
        RST = 1'b1;
        model_reset();
        #1;
        check_output("mid_rst_in_ready",    in_ready,    1);
        check_output("mid_rst_table_ready", table_ready, 0);
        check_output("mid_rst_solver_rst",  solver_rst,  1);
        check_output("mid_rst_lb",          lower_bound, 0);
        check_output("mid_rst_ferr",        frame_err,   0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        read_cost(0, 0, 0, "cost_cleared_0");
        read_cost(3, 5, 0, "cost_cleared_29");
        read_cost(5, 5, 0, "cost_cleared_45");
        load_frame(0);
        check_output("lb_after_rst", lower_bound, 224);
        check_output("ready_after_rst", table_ready, 1);
        apply_stimulus(1'b0, 0, 1'b0, 1'b0);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
